// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
package cic_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, RUN} ctrl_state_t;
  localparam int MIN_RATE = 2;
endpackage

// File: rtl/strobe_delay.sv
// DEPTH-cycle 1-bit strobe delay line with synchronous clear.
module strobe_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sr_q <= '0;
        else          sr_q <= clr_i ? 1'b0 : d_i;
    end else begin : g_many
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sr_q <= '0;
        else          sr_q <= clr_i ? '0 : {sr_q[DEPTH-2:0], d_i};
    end
  endgenerate

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC integrator-chain sequencer: counts input strobes, emits the decimated
// strobe aligned with the last integrator, and owns the decimation rate.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int STAGES       = 3,
  parameter int RATE_WIDTH   = 16,
  parameter int DEFAULT_RATE = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  inp_samp_str,
  input  logic [RATE_WIDTH-1:0] rate_in,
  input  logic                  rate_wr,
  output logic                  rate_busy,
  output logic                  rate_err,
  output logic [RATE_WIDTH-1:0] rate_cur,
  output logic [RATE_WIDTH-1:0] phase,
  output logic                  int_clr,
  output logic                  dec_str,
  output logic                  busy
);
  localparam int FW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [RATE_WIDTH-1:0] ONE = RATE_WIDTH'(1);

  ctrl_state_t           state_q, state_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic [RATE_WIDTH-1:0] phase_q, phase_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] pend_q, pend_d;
  logic                  pvld_q, pvld_d;
  logic                  err_q, err_d;
  logic                  acc, wrap, dly_clr, dly_in;

  assign acc  = (state_q == RUN) && inp_samp_str;
  assign wrap = acc && (phase_q == rate_q - ONE);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      flush_q <= '0;
      phase_q <= '0;
      rate_q  <= RATE_WIDTH'(DEFAULT_RATE);
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      err_q   <= err_d;
    end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    phase_d = phase_q;
    rate_d  = rate_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    err_d   = 1'b0;
    dly_clr = 1'b1;
    dly_in  = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (enable) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        if (!enable)                      state_d = IDLE;
        else if (flush_q == FW'(STAGES-1)) state_d = RUN;
        else                              flush_d = flush_q + 1'b1;
      end
      RUN: begin
        // Stopping kills any wrap still travelling down the delay line.
        if (!enable) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          dly_clr = 1'b0;
          dly_in  = wrap;
          if (wrap)     phase_d = '0;
          else if (acc) phase_d = phase_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Apply uses the old pending value, so a write on the wrap edge waits a period.
    if (pvld_q && (state_q != RUN || wrap)) begin
      rate_d = pend_q;
      pvld_d = 1'b0;
    end
    if (rate_wr) begin
      if (rate_in >= RATE_WIDTH'(MIN_RATE)) begin
        pend_d = rate_in;
        pvld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  strobe_delay #(.DEPTH(STAGES)) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (dly_clr),
    .d_i     (dly_in),
    .q_o     (dec_str)
  );

  assign rate_busy = pvld_q;
  assign rate_err  = err_q;
  assign rate_cur  = rate_q;
  assign phase     = phase_q;
  assign int_clr   = (state_q != RUN);
  assign busy      = (state_q == RUN);
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; dec_str timing checked through a scoreboard.
module tb_cic_decim_ctrl;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset_n, enable, inp_samp_str, rate_wr;
  logic [RW-1:0] rate_in;
  logic          rate_busy, rate_err, int_clr, dec_str, busy;
  logic [RW-1:0] rate_cur, phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int expq[$];

  cic_decim_ctrl #(.STAGES(3), .RATE_WIDTH(RW), .DEFAULT_RATE(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .inp_samp_str(inp_samp_str),
    .rate_in(rate_in), .rate_wr(rate_wr), .rate_busy(rate_busy), .rate_err(rate_err),
    .rate_cur(rate_cur), .phase(phase), .int_clr(int_clr), .dec_str(dec_str), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every dec_str must match the head of the expected-cycle queue.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0] < cyc) begin
      total++; bad++;
      $display("FAIL dec_str_missing: expected at cycle %0d, still absent at cycle %0d", expq[0], cyc);
      void'(expq.pop_front());
    end
    if (dec_str) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL dec_str_unexpected: seen at cycle %0d, none expected", cyc);
      end else begin
        if (expq[0] != cyc) begin
          bad++;
          $display("FAIL dec_str_cycle: got %0d expected %0d", cyc, expq[0]);
        end
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One decimation period of r continuous strobes; optional rate writes at
  // strobe indices wa/wb. Pushes the dec_str cycle for the closing wrap.
  task automatic period(input int r, input bit exp_dec,
                        input int wa, input int va, input int wb, input int vb);
    for (int i = 0; i < r; i++) begin
      inp_samp_str = 1'b1;
      rate_wr = (i == wa) || (i == wb);
      rate_in = (i == wb) ? RW'(vb) : RW'(va);
      if (i == r - 1 && exp_dec) expq.push_back(cyc + 3);
      tick();
      if ((i == wa || i == wb) && i < r - 1) chk("busy_after_wr", rate_busy, 1);
    end
    rate_wr = 1'b0;
    chk("phase_after_wrap", phase, 0);
  endtask

  task automatic flush_seq();
    enable = 1'b1; inp_samp_str = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_int_clr", int_clr, 1);
      chk("flush_phase", phase, 0);
    end
    tick();
    chk("run_busy", busy, 1);
    chk("run_int_clr", int_clr, 0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; inp_samp_str = 1'b0; rate_wr = 1'b0; rate_in = '0;
    tick(); tick();
    reset_n = 1'b1;
    // Get into RUN with a nonzero phase, then reset mid-cycle.
    enable = 1'b1;
    repeat (4) tick();
    inp_samp_str = 1'b1;
    repeat (3) tick();
    inp_samp_str = 1'b0; enable = 1'b0;
    chk("pre_rst_phase", phase, 3);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_int_clr", int_clr, 1);
    chk("rst_dec_str", dec_str, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rate_cur", rate_cur, 8);
    chk("rst_phase", phase, 0);
    chk("rst_rate_busy", rate_busy, 0);
    chk("rst_rate_err", rate_err, 0);
    tick();
    reset_n = 1'b1;

    // Rate write in IDLE applies on the following edge.
    rate_in = 16'd4; rate_wr = 1'b1;
    tick();
    rate_wr = 1'b0;
    chk("idle_wr_busy", rate_busy, 1);
    chk("idle_wr_rate_old", rate_cur, 8);
    tick();
    chk("idle_apply_rate", rate_cur, 4);
    chk("idle_apply_busy", rate_busy, 0);

    flush_seq();
    period(4, 1, -1, 0, -1, 0);
    period(4, 1, -1, 0, -1, 0);
    // Mid-period rate change to 6 at phase 1.
    period(4, 1, 1, 6, -1, 0);
    chk("chg_rate_cur", rate_cur, 6);
    chk("chg_rate_busy", rate_busy, 0);
    period(6, 1, -1, 0, -1, 0);

    // Illegal rates.
    inp_samp_str = 1'b0;
    for (int v = 1; v >= 0; v--) begin
      rate_in = RW'(v); rate_wr = 1'b1;
      tick();
      rate_wr = 1'b0;
      chk("err_pulse", rate_err, 1);
      chk("err_rate_busy", rate_busy, 0);
      chk("err_rate_cur", rate_cur, 6);
      tick();
      chk("err_cleared", rate_err, 0);
    end

    // Back-to-back writes: last wins. Then a write on the wrap strobe.
    period(6, 1, 0, 5, 1, 7);
    chk("b2b_rate_cur", rate_cur, 7);
    period(7, 1, 6, 9, -1, 0);
    chk("wrapwr_rate_cur", rate_cur, 7);
    chk("wrapwr_busy", rate_busy, 1);
    period(7, 1, -1, 0, -1, 0);
    chk("wrapwr_applied", rate_cur, 9);
    chk("wrapwr_busy_clr", rate_busy, 0);

    // Stop one cycle after a wrap edge: that wrap's dec_str is suppressed.
    period(9, 0, -1, 0, -1, 0);
    enable = 1'b0; inp_samp_str = 1'b0;
    tick();
    chk("stop_int_clr", int_clr, 1);
    chk("stop_phase", phase, 0);
    chk("stop_busy", busy, 0);
    repeat (5) tick();
    flush_seq();
    period(9, 1, -1, 0, -1, 0);
    inp_samp_str = 1'b0;
    repeat (8) tick();
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
